// File: rtl/bsg_cycle_timer_pkg.sv
// Shared types for the cycle timer: the two-state controller encoding.
package bsg_cycle_timer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/bsg_cycle_timer_if.sv
// Load/control/status bundle of the cycle timer.
// The master loads and steers the timer; the slave is the timer itself.
interface bsg_cycle_timer_if #(
  parameter int width_p = 16
);

  logic               v_i;
  logic [width_p-1:0] count_i;
  logic               periodic_i;
  logic               ready_o;
  logic               hold_i;
  logic               cancel_i;
  logic               busy_o;
  logic [width_p-1:0] remaining_o;
  logic               expire_o;

  modport master (
    output v_i, count_i, periodic_i, hold_i, cancel_i,
    input  ready_o, busy_o, remaining_o, expire_o
  );

  modport slave (
    input  v_i, count_i, periodic_i, hold_i, cancel_i,
    output ready_o, busy_o, remaining_o, expire_o
  );

endinterface

// File: rtl/bsg_counter_set_down.sv
// Loadable down-counter: set_i loads val_i, otherwise down_i decrements.
// The caller guarantees down_i is never asserted at zero.
module bsg_counter_set_down #(
  parameter int width_p = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               set_i,
  input  logic [width_p-1:0] val_i,
  input  logic               down_i,
  output logic [width_p-1:0] count_r_o
);

  localparam logic [width_p-1:0] ONE = width_p'(1);

  logic [width_p-1:0] r_count;

  // Count register: load has priority over decrement.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (set_i) begin
      r_count <= val_i;
    end else if (down_i) begin
      r_count <= r_count - ONE;
    end
  end

  assign count_r_o = r_count;

endmodule

// File: rtl/bsg_cycle_timer.sv
// Cycle timer: load N, count down to zero, pulse expire, then either
// go idle (one-shot) or reload N (periodic, period N+1). Cancel beats
// expiry and hold; hold freezes the count but never masks an expiry.
module bsg_cycle_timer
  import bsg_cycle_timer_pkg::*;
#(
  parameter int width_p = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  bsg_cycle_timer_if.slave     tif
);

  state_e             r_state;
  state_e             w_state_next;
  logic [width_p-1:0] r_reload;
  logic               r_periodic;

  logic               w_ready;
  logic               w_load;
  logic               w_set;
  logic [width_p-1:0] w_set_val;
  logic               w_down;
  logic               w_expire;
  logic [width_p-1:0] w_remaining;
  logic               w_zero;

  assign w_ready = (r_state == IDLE) && !reset;
  assign w_zero  = (w_remaining == '0);

  // State register plus the reload value and mode captured on a load.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_reload   <= '0;
      r_periodic <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_load) begin
        r_reload   <= tif.count_i;
        r_periodic <= tif.periodic_i;
      end
    end
  end

  // Next state, expiry pulse and counter load/decrement control.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_set        = 1'b0;
    w_set_val    = r_reload;
    w_down       = 1'b0;
    w_expire     = 1'b0;
    case (r_state)
      IDLE: begin
        if (tif.v_i && w_ready) begin
          w_load       = 1'b1;
          w_set        = 1'b1;
          w_set_val    = tif.count_i;
          w_state_next = RUN;
        end
      end
      RUN: begin
        if (tif.cancel_i) begin
          w_set        = 1'b1;
          w_set_val    = '0;
          w_state_next = IDLE;
        end else if (w_zero) begin
          w_expire = !reset;
          if (r_periodic) begin
            w_set     = 1'b1;
            w_set_val = r_reload;
          end else begin
            w_state_next = IDLE;
          end
        end else if (!tif.hold_i) begin
          w_down = 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  bsg_counter_set_down #(
    .width_p(width_p)
  ) u_counter (
    .clk      (clk),
    .reset    (reset),
    .set_i    (w_set),
    .val_i    (w_set_val),
    .down_i   (w_down),
    .count_r_o(w_remaining)
  );

  assign tif.ready_o     = w_ready;
  assign tif.busy_o      = (r_state == RUN);
  assign tif.remaining_o = w_remaining;
  assign tif.expire_o    = w_expire;

endmodule
